// File: rtl/rr_arb_pkg.sv
// Shared types and default sizing for the round-robin burst arbiter.
// Contents:
//   arb_state_t      - arbiter FSM state (idle / grant held)
//   ARB_N_DEF        - default number of requesters
//   ARB_MAX_HOLD_DEF - default maximum consecutive cycles a grant is held
package rr_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N_DEF        = 4;
  localparam int ARB_MAX_HOLD_DEF = 8;

endpackage : rr_arb_pkg

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// The search starts at index ptr and walks upward modulo N. The first set
// request bit wins.
// Ports:
//   req    [N]  - candidate requests
//   ptr    [IW] - index that has the highest priority this cycle
//   onehot [N]  - one-hot winner (all-zero when no request is set)
//   idx    [IW] - winner index (0 when no request is set)
//   any         - at least one request is set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Rotating first-set search; "take" fires only for the first hit so the
  // result is one-hot by construction.
  always_comb begin
    int unsigned j;
    logic        take;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    take   = 1'b0;
    for (int i = 0; i < N; i++) begin
      j         = (int'(ptr) + i) % N;
      take      = req[j] & ~any;
      onehot[j] = take;
      idx       = take ? IW'(j) : idx;
      any       = any | req[j];
    end
  end

endmodule : rr_pick

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter with a registered one-hot grant.
// An owner keeps the grant until it signals done, drops or loses its
// (masked) request, or reaches MAX_HOLD consecutive cycles. On release the
// arbiter re-arbitrates in the same edge, so the grant can move with no
// idle gap.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   req   [N]    - level requests
//   done  [N]    - end-of-burst; only the current owner's bit is honoured
//   mask  [N]    - 1 enables a requester (eff_req = req & mask)
//   grant [N]    - registered one-hot grant, zero when idle
//   grant_id[IW] - index of the current or last owner
//   busy         - grant active (equals |grant)
//   preempt      - one-cycle pulse after a release forced by the hold limit
module rr_burst_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = ARB_N_DEF,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
  parameter int IW       = $clog2(N),
  parameter int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          busy,
  output logic          preempt
);

  arb_state_t    state_q;
  logic [N-1:0]  grant_q;
  logic [IW-1:0] grant_id_q;
  logic          busy_q;
  logic          preempt_q;
  logic [IW-1:0] ptr_q;
  logic [CW-1:0] hold_cnt_q;

  logic [N-1:0]  eff_req_s;
  logic [N-1:0]  pick_onehot_s;
  logic [IW-1:0] pick_idx_s;
  logic          pick_any_s;
  logic          own_done_s;
  logic          own_req_s;
  logic          at_limit_s;
  logic          release_s;
  logic          preempt_d;
  logic [IW-1:0] ptr_d;

  assign eff_req_s = req & mask;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (eff_req_s),
    .ptr    (ptr_q),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // Release decision for the current owner and the pointer past the winner.
  always_comb begin
    own_done_s = done[grant_id_q];
    own_req_s  = eff_req_s[grant_id_q];
    at_limit_s = (hold_cnt_q == CW'(MAX_HOLD));
    release_s  = (state_q == ARB_GRANT) & (own_done_s | ~own_req_s | at_limit_s);
    // Preemption only when the owner still wanted the resource.
    preempt_d  = release_s & at_limit_s & ~own_done_s & own_req_s;
    if (pick_idx_s == IW'(N - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = pick_idx_s + IW'(1);
    end
  end

  // Arbiter FSM with registered grant, id, busy and preempt outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_any_s) begin
            state_q    <= ARB_GRANT;
            grant_q    <= pick_onehot_s;
            grant_id_q <= pick_idx_s;
            busy_q     <= 1'b1;
            ptr_q      <= ptr_d;
            hold_cnt_q <= CW'(1);
          end else begin
            state_q <= ARB_IDLE;
          end
        end
        ARB_GRANT: begin
          if (release_s) begin
            preempt_q <= preempt_d;
            if (pick_any_s) begin
              // Direct handover; ptr already sits past the old owner so it
              // re-wins only when it is the sole effective requester.
              grant_q    <= pick_onehot_s;
              grant_id_q <= pick_idx_s;
              ptr_q      <= ptr_d;
              hold_cnt_q <= CW'(1);
            end else begin
              // grant_id keeps the last owner while idle.
              state_q    <= ARB_IDLE;
              grant_q    <= '0;
              busy_q     <= 1'b0;
              hold_cnt_q <= '0;
            end
          end else if (!at_limit_s) begin
            hold_cnt_q <= hold_cnt_q + CW'(1);
          end else begin
            hold_cnt_q <= hold_cnt_q;
          end
        end
        default: begin
          state_q    <= ARB_IDLE;
          grant_q    <= '0;
          busy_q     <= 1'b0;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign preempt  = preempt_q;

endmodule : rr_burst_arbiter

// File: tb/tb_rr_burst_arbiter.sv
// Directed testbench for rr_burst_arbiter (N=4, MAX_HOLD=4).
module tb_rr_burst_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IW       = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  mask;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          preempt;

  int n_checks;
  int n_pass;

  rr_burst_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .mask     (mask),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .preempt  (preempt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    logic [N-1:0] exp_g;
    logic         exp_p;
    logic [N-1:0] rot [5];
    logic [N-1:0] mseq [3];

    n_checks = 0;
    n_pass   = 0;
    rst  = 1'b0;
    req  = 4'b0000;
    done = 4'b0000;
    mask = 4'b1111;

    // Reset state
    step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_gid", 32'(grant_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_preempt", 32'(preempt), 32'h0);
    rst = 1'b1;

    // Rotation: each owner signals done on its first grant cycle
    rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100;
    rot[3] = 4'b1000; rot[4] = 4'b0001;
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("rot_grant%0d", c), 32'(grant), 32'(rot[c]));
      check($sformatf("rot_busy%0d", c), 32'(busy), 32'h1);
      check($sformatf("rot_preempt%0d", c), 32'(preempt), 32'h0);
      done = grant;
    end
    done = 4'b0000;
    req  = 4'b0000;
    step();
    check("rot_idle", 32'(grant), 32'h0);
    check("rot_gid_kept", 32'(grant_id), 32'h0);

    // Hold limit: two requesters alternate every MAX_HOLD cycles
    do_reset();
    req = 4'b0011;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_g = (((c - 1) / MAX_HOLD) % 2 == 0) ? 4'b0001 : 4'b0010;
      exp_p = (c > 1) && ((c - 1) % MAX_HOLD == 0);
      check($sformatf("hold_grant%0d", c), 32'(grant), 32'(exp_g));
      check($sformatf("hold_preempt%0d", c), 32'(preempt), 32'(exp_p));
    end

    // Sole requester: regranted on every limit, never idle
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 10; c++) begin
      step();
      exp_p = (c > 1) && ((c - 1) % MAX_HOLD == 0);
      check($sformatf("sole_grant%0d", c), 32'(grant), 32'h4);
      check($sformatf("sole_preempt%0d", c), 32'(preempt), 32'(exp_p));
    end
    check("sole_gid", 32'(grant_id), 32'h2);

    // Mask: requester 1 disabled, done held high so every grant lasts a cycle
    do_reset();
    mseq[0] = 4'b0001; mseq[1] = 4'b0100; mseq[2] = 4'b1000;
    mask = 4'b1101;
    req  = 4'b1111;
    done = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("mask_grant%0d", c), 32'(grant), 32'(mseq[c % 3]));
      check($sformatf("mask_preempt%0d", c), 32'(preempt), 32'h0);
    end

    // Drop by mask: owner 0 masked off hands over to 3 with no gap
    done = 4'b0000;
    do_reset();
    mask = 4'b1111;
    req  = 4'b1001;
    step();
    check("drop_first", 32'(grant), 32'h1);
    mask = 4'b1110;
    step();
    check("drop_handover", 32'(grant), 32'h8);
    check("drop_busy", 32'(busy), 32'h1);
    check("drop_preempt", 32'(preempt), 32'h0);
    done = 4'b0100;
    step();
    check("nonowner_done1", 32'(grant), 32'h8);
    step();
    check("nonowner_done2", 32'(grant), 32'h8);
    done = 4'b0000;

    // Idle and one-cycle latency
    do_reset();
    mask = 4'b1111;
    req  = 4'b0000;
    step();
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    req = 4'b1000;
    #1;
    check("lat_before_edge", 32'(grant), 32'h0);
    step();
    check("lat_grant", 32'(grant), 32'h8);
    check("lat_gid", 32'(grant_id), 32'h3);
    req = 4'b0000;
    step();
    check("lat_release", 32'(grant), 32'h0);
    check("lat_busy", 32'(busy), 32'h0);
    check("lat_gid_kept", 32'(grant_id), 32'h3);

    // Reset mid-burst, right while preempt is high
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      step();
    end
    check("mid_owner", 32'(grant), 32'h4);
    check("mid_preempt_hi", 32'(preempt), 32'h1);
    rst = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_preempt", 32'(preempt), 32'h0);
    check("mid_rst_gid", 32'(grant_id), 32'h0);
    req = 4'b1111;
    #2;
    rst = 1'b1;
    step();
    check("post_rst_grant", 32'(grant), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rr_burst_arbiter
